// File: rtl/pid_pkg.sv
// Shared definitions for the PI loop: default datapath widths, pipeline latency
// and the sequencer state encoding.
package pid_pkg;

  localparam int unsigned PID_INPUT_WIDTH      = 18;
  localparam int unsigned PID_OUTPUT_WIDTH     = 32;
  localparam int unsigned PID_DAC_WIDTH        = 20;
  localparam int unsigned PID_PIPELINE_LATENCY = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADC_WAIT  = 3'd1,
    ST_PIPE_WAIT = 3'd2,
    ST_COMMIT    = 3'd3,
    ST_DAC_WAIT  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/sat_signed.sv
// Combinational signed saturation of a wide two's-complement value into a
// narrower one; clamps to the narrow type's max/min when the value does not fit.
module sat_signed #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 20
) (
  input  logic [IN_WIDTH-1:0]  data_i,
  output logic [OUT_WIDTH-1:0] data_o
);

  logic [IN_WIDTH-OUT_WIDTH:0] top_s;

  // The value fits when every bit from the narrow sign bit upward agrees.
  assign top_s = data_i[IN_WIDTH-1:OUT_WIDTH-1];

  // Pass through, or clamp toward the sign of the input.
  always_comb begin
    if ((&top_s) || !(|top_s)) begin
      data_o = data_i[OUT_WIDTH-1:0];
    end else if (data_i[IN_WIDTH-1]) begin
      data_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      data_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/pi_loop_sequencer.sv
// Sequences one PI iteration per loop: ADC sample, pipeline wait, integral
// commit, saturated DAC write. Owns the integral state register.
module pi_loop_sequencer
  import pid_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH      = PID_INPUT_WIDTH,
  parameter int unsigned OUTPUT_WIDTH     = PID_OUTPUT_WIDTH,
  parameter int unsigned DAC_WIDTH        = PID_DAC_WIDTH,
  parameter int unsigned PIPELINE_LATENCY = PID_PIPELINE_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic                    i_clear_integral,
  input  logic                    i_adc_finished,
  input  logic [INPUT_WIDTH-1:0]  i_adc_data,
  output logic                    o_adc_arm,
  input  logic [OUTPUT_WIDTH-1:0] i_pipe_integral,
  input  logic [OUTPUT_WIDTH-1:0] i_pipe_out,
  output logic [INPUT_WIDTH-1:0]  o_actual,
  output logic [OUTPUT_WIDTH-1:0] o_integral,
  output logic                    o_dac_arm,
  output logic [DAC_WIDTH-1:0]    o_dac_data,
  input  logic                    i_dac_finished,
  output logic                    o_running,
  output logic [31:0]             o_loop_count
);

  localparam int unsigned CNT_WIDTH = $clog2(PIPELINE_LATENCY + 2);
  localparam logic [CNT_WIDTH-1:0] LAT_C = CNT_WIDTH'(PIPELINE_LATENCY);

  seq_state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     adc_arm_q, adc_arm_d;
  logic                     dac_arm_q, dac_arm_d;
  logic [INPUT_WIDTH-1:0]   actual_q, actual_d;
  logic [OUTPUT_WIDTH-1:0]  integral_q, integral_d;
  logic [DAC_WIDTH-1:0]     dac_data_q, dac_data_d;
  logic                     running_q, running_d;
  logic [31:0]              loop_count_q, loop_count_d;
  logic                     clr_pend_q, clr_pend_d;
  logic [DAC_WIDTH-1:0]     sat_s;

  sat_signed #(
    .IN_WIDTH  (OUTPUT_WIDTH),
    .OUT_WIDTH (DAC_WIDTH)
  ) u_sat (
    .data_i (i_pipe_out),
    .data_o (sat_s)
  );

  // Next-state and next-output logic for the loop sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    adc_arm_d    = adc_arm_q;
    dac_arm_d    = dac_arm_q;
    actual_d     = actual_q;
    integral_d   = integral_q;
    dac_data_d   = dac_data_q;
    loop_count_d = loop_count_q;
    clr_pend_d   = clr_pend_q;

    // A clear outside IDLE is deferred so it cannot race the pipeline's integral.
    if (i_clear_integral && (state_q != ST_IDLE) && (state_q != ST_COMMIT)) begin
      clr_pend_d = 1'b1;
    end else begin
      clr_pend_d = clr_pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_clear_integral) begin
          integral_d = {OUTPUT_WIDTH{1'b0}};
        end else begin
          integral_d = integral_q;
        end
        if (i_enable) begin
          state_d   = ST_ADC_WAIT;
          adc_arm_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADC_WAIT: begin
        if (i_adc_finished) begin
          actual_d  = i_adc_data;
          adc_arm_d = 1'b0;
          cnt_d     = LAT_C;
          state_d   = ST_PIPE_WAIT;
        end else begin
          state_d = ST_ADC_WAIT;
        end
      end
      ST_PIPE_WAIT: begin
        if (cnt_q == {CNT_WIDTH{1'b0}}) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_COMMIT: begin
        if (clr_pend_q || i_clear_integral) begin
          integral_d = {OUTPUT_WIDTH{1'b0}};
        end else begin
          integral_d = i_pipe_integral;
        end
        clr_pend_d = 1'b0;
        dac_data_d = sat_s;
        dac_arm_d  = 1'b1;
        state_d    = ST_DAC_WAIT;
      end
      ST_DAC_WAIT: begin
        if (i_dac_finished) begin
          dac_arm_d    = 1'b0;
          loop_count_d = loop_count_q + 32'd1;
          if (i_enable) begin
            state_d   = ST_ADC_WAIT;
            adc_arm_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DAC_WAIT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        adc_arm_d = 1'b0;
        dac_arm_d = 1'b0;
      end
    endcase

    running_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_WIDTH{1'b0}};
      adc_arm_q    <= 1'b0;
      dac_arm_q    <= 1'b0;
      actual_q     <= {INPUT_WIDTH{1'b0}};
      integral_q   <= {OUTPUT_WIDTH{1'b0}};
      dac_data_q   <= {DAC_WIDTH{1'b0}};
      running_q    <= 1'b0;
      loop_count_q <= 32'd0;
      clr_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      adc_arm_q    <= adc_arm_d;
      dac_arm_q    <= dac_arm_d;
      actual_q     <= actual_d;
      integral_q   <= integral_d;
      dac_data_q   <= dac_data_d;
      running_q    <= running_d;
      loop_count_q <= loop_count_d;
      clr_pend_q   <= clr_pend_d;
    end
  end

  assign o_adc_arm    = adc_arm_q;
  assign o_dac_arm    = dac_arm_q;
  assign o_actual     = actual_q;
  assign o_integral   = integral_q;
  assign o_dac_data   = dac_data_q;
  assign o_running    = running_q;
  assign o_loop_count = loop_count_q;

endmodule

// File: doc/pi_loop_sequencer.md
Name: pi_loop_sequencer

Overview:
Sequences one closed-loop PI iteration around the four-stage PI pipeline. Each iteration requests an ADC sample, presents it to the pipeline with the stored integral, and waits out the pipeline latency. It then commits the updated integral, saturates the controller output to DAC width, and requests a DAC write. The block sits between the ADC/DAC handshake masters and the PI pipeline, and owns the integral state register.

Parameters:
INPUT_WIDTH, 18, signed width of setpoint/actual/gains fed to the pipeline
OUTPUT_WIDTH, 32, signed width of integral and pipeline output
DAC_WIDTH, 20, signed width of value written to DAC
PIPELINE_LATENCY, 4, clocks from stable pipeline inputs to valid pipeline output

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_enable  in  1  run loop continuously while high
i_clear_integral  in  1  single-cycle request to zero the integral
i_adc_finished  in  1  ADC conversion done (pulse or level)
i_adc_data  in  INPUT_WIDTH  signed ADC sample; valid when i_adc_finished high
o_adc_arm  out  1  ADC conversion request
i_pipe_integral  in  OUTPUT_WIDTH  updated integral from pipeline
i_pipe_out  in  OUTPUT_WIDTH  PI output from pipeline
o_actual  out  INPUT_WIDTH  sample presented to pipeline
o_integral  out  OUTPUT_WIDTH  stored integral presented to pipeline
o_dac_arm  out  1  DAC write request
o_dac_data  out  DAC_WIDTH  saturated output to DAC
i_dac_finished  in  1  DAC write done
o_running  out  1  high in any state other than IDLE
o_loop_count  out  32  completed iterations

Behaviour:
- Reset (rst high at clk edge): state IDLE. o_adc_arm=0, o_dac_arm=0, o_actual=0, o_integral=0, o_dac_data=0, o_running=0, o_loop_count=0, clear-pending flag=0. Takes priority over everything, mid-iteration included. Arms drop on the same edge.
- States: IDLE, ADC_WAIT, PIPE_WAIT, COMMIT, DAC_WAIT.
- IDLE:
  - If i_clear_integral is high, o_integral<=0 immediately.
  - If i_enable is high, go to ADC_WAIT with o_adc_arm<=1.
- ADC_WAIT:
  - Hold o_adc_arm=1 until i_adc_finished is sampled high.
  - On that edge: o_actual<=i_adc_data, o_adc_arm<=0, wait counter<=PIPELINE_LATENCY, go to PIPE_WAIT.
- PIPE_WAIT:
  - o_actual and o_integral are held constant.
  - Counter decrements each cycle; when it is 0, go to COMMIT.
  - Total: PIPELINE_LATENCY+1 clocks from the o_actual update to COMMIT.
- COMMIT (one cycle):
  - o_integral<=i_pipe_integral, or 0 if clear-pending; clear-pending<=0.
  - o_dac_data<=sat(i_pipe_out).
  - o_dac_arm<=1; go to DAC_WAIT.
- DAC_WAIT:
  - Hold o_dac_arm=1 and o_dac_data stable until i_dac_finished is sampled high.
  - On that edge: o_dac_arm<=0, o_loop_count<=o_loop_count+1 (wraps at 2^32).
  - If i_enable is high, go to ADC_WAIT with o_adc_arm<=1 (no idle cycle); otherwise go to IDLE.
- i_enable is sampled only in IDLE and at DAC completion. Dropping it mid-iteration completes the current iteration.
- i_clear_integral outside IDLE sets clear-pending, which is applied at the next COMMIT. Repeated pulses are idempotent.
- Saturation:
  - if i_pipe_out > 2^(DAC_WIDTH-1)-1, output 2^(DAC_WIDTH-1)-1;
  - if i_pipe_out < -2^(DAC_WIDTH-1), output -2^(DAC_WIDTH-1);
  - otherwise output the low DAC_WIDTH bits. Signed comparison.
- Finished inputs arriving when not in the matching wait state are ignored.
- If a finished input is already high on the cycle its arm rises, it is not consumed. It is consumed on the first edge where arm=1 and finished=1.
- Minimum iteration length with zero-wait ADC/DAC: 1 (ADC) + PIPELINE_LATENCY+1 + 1 (COMMIT) + 1 (DAC) clocks.

Decomposition:
- Shared package pid_pkg: state encoding constants and the default widths (18/32/20/4).
- One natural sub-module, sat_signed: combinational signed saturation from OUTPUT_WIDTH to DAC_WIDTH, reusable by other DAC writers.
- The FSM, counter and integral register stay in pi_loop_sequencer.

Test Plan:
- Reset mid-PIPE_WAIT -> next cycle all outputs are 0, state IDLE, o_running=0.
- i_enable=1, ADC and DAC respond after 1 cycle, i_adc_data=100, i_pipe_integral=100, i_pipe_out=500 -> o_integral=100, o_dac_data=500, o_dac_arm rises exactly 6 clocks after o_actual=100, o_loop_count=1.
- Saturation: i_pipe_out=32'h7FFFFFFF -> o_dac_data=20'h7FFFF; i_pipe_out=-2000000 -> 20'h80000; i_pipe_out=-5 -> 20'hFFFFB.
- i_clear_integral pulsed during ADC_WAIT while i_pipe_integral=1234 -> after COMMIT o_integral=0; next iteration commits normally.
- i_enable dropped during PIPE_WAIT -> DAC write still occurs, o_loop_count increments, then IDLE with o_adc_arm=0.
- Stray i_adc_finished in IDLE and DAC_WAIT -> no state change, o_actual unchanged.
